// File: rtl/addsub_checker.sv
// Self-checking monitor for an adder/subtractor: computes the expected {carry, sum, overflow}
// for each accepted operand set, delays it LATENCY cycles and scores the DUT's answer.
module addsub_checker #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             dut_carry,
    input  logic             dut_overflow,
    input  logic [WIDTH-1:0] dut_s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      txn_count,
    output logic [15:0]      err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_op
);
    localparam int RW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic               done_q;

    logic               vld_p [LATENCY];
    logic [WIDTH-1:0]   a_p   [LATENCY];
    logic [WIDTH-1:0]   b_p   [LATENCY];
    logic               op_p  [LATENCY];
    logic [RW-1:0]      exp_p [LATENCY];

    logic               accept;
    logic               check;
    logic               mismatch;
    logic               in_flight;

    // Packed as {carry, s, overflow}; subtract is A + ~B + 1 so carry means "no borrow".
    function automatic logic [RW-1:0] expected_result(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b,
                                                      input logic             op);
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH:0]   sum;
        logic             ovf;
        b_eff = op ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op};
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        return {sum, ovf};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    assign accept   = (state_q == RUN) && in_valid && !start;
    assign check    = vld_p[LATENCY-1];
    assign mismatch = ({dut_carry, dut_s, dut_overflow} != exp_p[LATENCY-1]);

    // The last stage is being scored this cycle, so only earlier stages keep DRAIN open.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            in_flight = in_flight | vld_p[i];
        end
    end

    // Stage p0: accept operands and expected result; stages p1.. shift toward the compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else if (start) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        a_p[0]   <= in_a;
        b_p[0]   <= in_b;
        op_p[0]  <= in_op;
        exp_p[0] <= expected_result(in_a, in_b, in_op);
        for (int i = 1; i < LATENCY; i++) begin
            a_p[i]   <= a_p[i-1];
            b_p[i]   <= b_p[i-1];
            op_p[i]  <= op_p[i-1];
            exp_p[i] <= exp_p[i-1];
        end
    end

    // Compare stage: score the DUT against the oldest entry of the delay line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txn_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_op    <= 1'b0;
        end else if (start) begin
            txn_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_op    <= 1'b0;
        end else if (check) begin
            txn_count <= sat_inc(txn_count);
            if (mismatch) begin
                err_count <= sat_inc(err_count);
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_a     <= a_p[LATENCY-1];
                    first_err_b     <= b_p[LATENCY-1];
                    first_err_op    <= op_p[LATENCY-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DRAIN) && (state_d == DONE);
        end
    end

    // start wins over stop in every state, including a simultaneous pulse.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (stop) state_d = DRAIN;
                DRAIN:   if (!in_flight) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DRAIN);
        pass = (state_q == DONE) && (err_count == 16'd0);
        done = done_q;
    end

endmodule
